// File: rtl/keypad_scan_fifo_if.sv
// Keypad pin bundle plus the key-code FIFO read port of the scanner.
// master = scanner side (drives rows, presents codes); slave = board/consumer side.
// Widths follow the keypad geometry and FIFO depth parameters.
interface keypad_scan_fifo_if #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int FIFO_DEPTH = 4
);
  localparam int KEY_W = $clog2(ROWS * COLS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [ROWS-1:0]  row_out;
  logic [COLS-1:0]  col_in;
  logic [KEY_W-1:0] key_out;
  logic             ready;
  logic             ack;
  logic             pressed;
  logic             overflow;
  logic             ovf_clr;
  logic [CNT_W-1:0] count;

  modport master (
    output row_out, key_out, ready, pressed, overflow, count,
    input  col_in, ack, ovf_clr
  );

  modport slave (
    input  row_out, key_out, ready, pressed, overflow, count,
    output col_in, ack, ovf_clr
  );
endinterface

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: row drive, per-frame single-key decode, frame debounce, key-code FIFO.
// Latency: a key is queued DEBOUNCE frames after first seen; ready rises one cycle after that frame end.
// Backpressure: codes wait in the FIFO until acked; a push into a full FIFO without a same-edge pop is dropped and flagged.
module keypad_scan_fifo #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 65536,
  parameter int DEBOUNCE   = 12,
  parameter int FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  keypad_scan_fifo_if.master kp
);
  localparam int KEY_W = $clog2(ROWS * COLS);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int RUN_W = $clog2(DEBOUNCE + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {CAND_NONE, CAND_KEY, CAND_MULTI} cand_kind_e;
  typedef struct packed {
    cand_kind_e       kind;
    logic [KEY_W-1:0] key;   // zero unless kind is CAND_KEY, so struct equality is exact
  } cand_t;

  localparam cand_t CAND_IDLE = '{kind: CAND_NONE, key: '0};

  logic [COLS-1:0]  col_meta, col_sync;
  logic [DIV_W-1:0] div_cnt;
  logic [ROW_W-1:0] row_idx;
  logic             sample, frame_end;
  logic [1:0]       row_hits, base_hits, frame_hits, acc_hits;
  logic [2:0]       hit_sum;
  logic [COL_W-1:0] row_col;
  logic [KEY_W-1:0] frame_key, acc_key;
  cand_t            cand, last_cand, stable;
  logic [RUN_W-1:0] run_cnt, run_nxt;
  logic             stable_upd, push;
  logic [KEY_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, fifo_cnt;
  logic             not_empty, full, pop, do_write, drop, overflow_q;

  assign sample    = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_end = sample && (row_idx == ROW_W'(ROWS - 1));

  // Column lines are asynchronous: two-flop synchroniser, idle (released) level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= kp.col_in;
      col_sync <= col_meta;
    end
  end

  // Row dwell divider; the active row advances when the divider wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      row_idx <= '0;
    end else if (sample) begin
      div_cnt <= '0;
      row_idx <= (row_idx == ROW_W'(ROWS - 1)) ? '0 : row_idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign kp.row_out = ~(ROWS'(1) << row_idx);

  // Count low columns in the current row (saturating at 2) and remember the last low column.
  always_comb begin
    row_hits = 2'd0;
    row_col  = '0;
    for (int c = 0; c < COLS; c++) begin
      if (!col_sync[c]) begin
        if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
        row_col = COL_W'(c);
      end
    end
  end

  // Fold this row's hits into the frame tally; row 0 starts a fresh frame.
  always_comb begin
    base_hits  = (row_idx == '0) ? 2'd0 : acc_hits;
    hit_sum    = {1'b0, base_hits} + {1'b0, row_hits};
    frame_hits = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
    frame_key  = acc_key;
    if (row_hits == 2'd1 && base_hits == 2'd0)
      frame_key = KEY_W'(int'(row_idx) * COLS + int'(row_col));
  end

  // Frame tally registers, updated on every row sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hits <= 2'd0;
      acc_key  <= '0;
    end else if (sample) begin
      acc_hits <= frame_hits;
      acc_key  <= frame_key;
    end
  end

  // Frame candidate, debounce run length, and the stable-change / push decision.
  always_comb begin
    cand = CAND_IDLE;
    case (frame_hits)
      2'd0:    cand = CAND_IDLE;
      2'd1:    cand = '{kind: CAND_KEY, key: frame_key};
      default: cand = '{kind: CAND_MULTI, key: '0};
    endcase
    if (cand == last_cand)
      run_nxt = (run_cnt == RUN_W'(DEBOUNCE)) ? run_cnt : run_cnt + 1'b1;
    else
      run_nxt = RUN_W'(1);
    stable_upd = frame_end && (run_nxt == RUN_W'(DEBOUNCE)) && (cand != stable);
    // Any change of stable into KEY(k) is by construction a change from a different value.
    push       = stable_upd && (cand.kind == CAND_KEY);
  end

  // Debounce state advances once per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_cand <= CAND_IDLE;
      stable    <= CAND_IDLE;
      run_cnt   <= '0;
    end else if (frame_end) begin
      last_cand <= cand;
      run_cnt   <= run_nxt;
      if (stable_upd) stable <= cand;
    end
  end

  assign kp.pressed = (stable.kind == CAND_KEY);

  assign fifo_cnt  = wr_ptr - rd_ptr;
  assign not_empty = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = kp.ack && not_empty;
  assign do_write  = push && (!full || pop);
  assign drop      = push && full && !pop;

  // Key-code storage; not reset, contents are only meaningful while ready is high.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[AW-1:0]] <= cand.key;
  end

  // FIFO pointers and sticky overflow; a new drop wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      if (drop)            overflow_q <= 1'b1;
      else if (kp.ovf_clr) overflow_q <= 1'b0;
    end
  end

  assign kp.key_out  = mem[rd_ptr[AW-1:0]];
  assign kp.ready    = not_empty;
  assign kp.count    = fifo_cnt;
  assign kp.overflow = overflow_q;
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Bench for keypad_scan_fifo: keypad model on row/col pins, expected-code scoreboard, directed scenarios.
// All driving and sampling happens on the falling clock edge.
// The monitor compares the FIFO head against the scoreboard whenever an ack is presented with ready high.
module tb_keypad_scan_fifo;
  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE   = 3;
  localparam int FIFO_DEPTH = 2;
  localparam int FRAME      = ROWS * SCAN_DIV;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys  = '0;
  int          tests = 0;
  int          fails = 0;
  int          exp_q[$];
  bit          unexp_seen = 1'b0;

  keypad_scan_fifo_if #(.ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(FIFO_DEPTH)) bus();

  keypad_scan_fifo #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kp   (bus)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a held key pulls its column low while its row is driven low.
  always_comb begin
    bus.col_in = '1;
    for (int r = 0; r < ROWS; r++)
      if (!bus.row_out[r])
        for (int c = 0; c < COLS; c++)
          if (keys[r*COLS + c]) bus.col_in[c] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    step(n * FRAME);
  endtask

  task automatic pulse_ack();
    bus.ack = 1'b1;
    step(1);
    bus.ack = 1'b0;
  endtask

  // Scoreboard monitor: every accepted pop must match the oldest expected code.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus.ready && exp_q.size() == 0 && !unexp_seen) begin
        unexp_seen = 1'b1;
        tests++;
        fails++;
        $display("FAIL unexpected_entry: got key_out %0d, expected no queued code", bus.key_out);
      end
      if (rst_n && bus.ack && bus.ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_without_expectation: got key_out %0d, expected nothing", bus.key_out);
        end else begin
          check("pop_code", int'(bus.key_out), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.ack     = 1'b0;
    bus.ovf_clr = 1'b0;
    keys        = '0;
    rst_n       = 1'b0;

    // Reset, then a second reset in the middle of row 1.
    step(2);
    rst_n = 1'b1;
    step(6);
    check("row_before_reset", int'(bus.row_out), 'b1101);
    rst_n = 1'b0;
    #1;
    check("rst_row_out",  int'(bus.row_out),  'b1110);
    check("rst_ready",    int'(bus.ready),    0);
    check("rst_count",    int'(bus.count),    0);
    check("rst_pressed",  int'(bus.pressed),  0);
    check("rst_overflow", int'(bus.overflow), 0);
    step(1);
    rst_n = 1'b1;
    step(3);
    check("row0_dwell", int'(bus.row_out), 'b1110);
    step(1);
    check("row1_step",  int'(bus.row_out), 'b1101);
    step(FRAME - 4);

    // Single key at row 1 / col 2 -> code 6.
    keys = 16'h0040;
    exp_q.push_back(6);
    step(3 * FRAME - 1);
    check("single_ready_early", int'(bus.ready), 0);
    step(1);
    check("single_ready",   int'(bus.ready),   1);
    check("single_pressed", int'(bus.pressed), 1);
    check("single_key_out", int'(bus.key_out), 6);
    check("single_count",   int'(bus.count),   1);
    pulse_ack();
    check("single_ack_ready", int'(bus.ready), 0);
    check("single_ack_count", int'(bus.count), 0);
    step(FRAME - 1);
    frames(3);
    check("single_no_repeat",   int'(bus.count),   0);
    check("single_still_held",  int'(bus.pressed), 1);
    keys = '0;
    frames(3);
    check("single_release", int'(bus.pressed), 0);

    // Bounce: key 6 toggles every frame for 6 frames, then is held.
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      frames(1);
    end
    check("bounce_no_push", int'(bus.count), 0);
    keys = 16'h0040;
    exp_q.push_back(6);
    frames(2);
    check("bounce_ready_early", int'(bus.ready), 0);
    frames(1);
    check("bounce_ready", int'(bus.ready), 1);
    check("bounce_count", int'(bus.count), 1);
    pulse_ack();
    step(FRAME - 1);
    frames(2);
    check("bounce_single_push", int'(bus.count), 0);
    keys = '0;
    frames(3);

    // Multi-key: 0 and 5 together, then release 5.
    keys = 16'h0021;
    frames(4);
    check("multi_pressed", int'(bus.pressed), 0);
    check("multi_count",   int'(bus.count),   0);
    keys = 16'h0001;
    exp_q.push_back(0);
    frames(2);
    check("multi_release_early", int'(bus.ready), 0);
    frames(1);
    check("multi_release_ready",   int'(bus.ready),   1);
    check("multi_release_key",     int'(bus.key_out), 0);
    check("multi_release_pressed", int'(bus.pressed), 1);
    pulse_ack();
    step(FRAME - 1);
    keys = '0;
    frames(3);

    // Overflow: 3, 9, 15 with no ack; 15 is dropped.
    keys = 16'h0008;
    exp_q.push_back(3);
    frames(3);
    check("ovf_count1", int'(bus.count), 1);
    keys = '0;
    frames(3);
    keys = 16'h0200;
    exp_q.push_back(9);
    frames(3);
    check("ovf_count2",    int'(bus.count),    2);
    check("ovf_not_yet",   int'(bus.overflow), 0);
    keys = '0;
    frames(3);
    keys = 16'h8000;
    frames(3);
    check("ovf_count_full", int'(bus.count),    2);
    check("ovf_head",       int'(bus.key_out),  3);
    check("ovf_flag",       int'(bus.overflow), 1);
    pulse_ack();
    pulse_ack();
    check("ovf_drained", int'(bus.count), 0);
    check("ovf_sticky",  int'(bus.overflow), 1);
    bus.ovf_clr = 1'b1;
    step(1);
    bus.ovf_clr = 1'b0;
    check("ovf_cleared", int'(bus.overflow), 0);
    step(FRAME - 3);
    keys = '0;
    frames(3);

    // Simultaneous push of 12 and pop while the FIFO is full.
    keys = 16'h0002;
    exp_q.push_back(1);
    frames(3);
    keys = '0;
    frames(3);
    keys = 16'h0004;
    exp_q.push_back(2);
    frames(3);
    keys = '0;
    frames(3);
    check("sim_full", int'(bus.count), 2);
    keys = 16'h1000;
    exp_q.push_back(12);
    step(3 * FRAME - 1);
    bus.ack = 1'b1;
    step(1);
    bus.ack = 1'b0;
    check("sim_count",    int'(bus.count),    2);
    check("sim_overflow", int'(bus.overflow), 0);
    check("sim_head",     int'(bus.key_out),  2);
    pulse_ack();
    pulse_ack();
    check("sim_drained", int'(bus.count), 0);
    step(2);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
